// File: rtl/ixayoi_axil_ram_if.sv
// ixayoi_axil_ram_if
//   AXI4-Lite bus bundle for the ixayoi_axil_ram slave.
//
// Handshake rule (all five channels): a transfer happens on a rising clk edge
// where both valid and ready are high. Once valid is raised, the source holds
// valid and its payload stable until that edge. Ready may be raised or dropped
// freely and never depends combinationally on valid.
//
// Signals
//   AW : s_axi_awaddr[31:0], s_axi_awvalid, s_axi_awready
//   W  : s_axi_wdata[31:0], s_axi_wstrb[3:0], s_axi_wvalid, s_axi_wready
//   B  : s_axi_bresp[1:0], s_axi_bvalid, s_axi_bready
//   AR : s_axi_araddr[31:0], s_axi_arvalid, s_axi_arready
//   R  : s_axi_rdata[31:0], s_axi_rresp[1:0], s_axi_rvalid, s_axi_rready
// Modports
//   master : drives addresses, write data and the response readies
//   slave  : drives the address/data readies and the responses
interface ixayoi_axil_ram_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );
endinterface

// File: rtl/ixayoi_axil_ram.sv
// ixayoi_axil_ram
//   AXI4-Lite slave RAM of 2^DEPTH_LOG2 32-bit words. Byte-strobed writes,
//   one-cycle-latency reads, SLVERR outside the address window. The read and
//   write channels run independently; each has at most one transfer in flight.
//
// Parameters
//   DEPTH_LOG2 : log2 of the depth in words
//   BASE_ADDR  : window base, aligned to 2^(DEPTH_LOG2+2)
// Ports
//   clk          : clock
//   reset        : synchronous, active-high reset
//   s_axi        : AXI4-Lite slave bus (see ixayoi_axil_ram_if)
//   wr_state_dbg : write FSM state (0 idle, 1 AW held, 2 W held, 3 response)
//   rd_state_dbg : read FSM state (0 idle, 1 response)
module ixayoi_axil_ram #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  ixayoi_axil_ram_if.slave       s_axi,
  output logic [1:0]             wr_state_dbg,
  output logic                   rd_state_dbg
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int TAG_LSB = DEPTH_LOG2 + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_t;

  function automatic logic in_range(input logic [31:0] addr);
    return addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
  endfunction

  logic [31:0] mem [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_t   wr_state_q, wr_state_d;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q;

  logic        awready, wready;
  logic        commit;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [3:0]  commit_strb;

  // The commit mux picks each half of the write from either its holding
  // register or the live bus, so a same-cycle AW+W commits without a bubble.
  always_comb begin
    wr_state_d  = wr_state_q;
    awready     = 1'b0;
    wready      = 1'b0;
    commit      = 1'b0;
    commit_addr = aw_addr_q;
    commit_data = w_data_q;
    commit_strb = w_strb_q;
    case (wr_state_q)
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (s_axi.s_axi_awvalid && s_axi.s_axi_wvalid) begin
          commit      = 1'b1;
          commit_addr = s_axi.s_axi_awaddr;
          commit_data = s_axi.s_axi_wdata;
          commit_strb = s_axi.s_axi_wstrb;
          wr_state_d  = WR_RESP;
        end else if (s_axi.s_axi_awvalid) begin
          wr_state_d = WR_HAVE_AW;
        end else if (s_axi.s_axi_wvalid) begin
          wr_state_d = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        wready = 1'b1;
        if (s_axi.s_axi_wvalid) begin
          commit      = 1'b1;
          commit_data = s_axi.s_axi_wdata;
          commit_strb = s_axi.s_axi_wstrb;
          wr_state_d  = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        awready = 1'b1;
        if (s_axi.s_axi_awvalid) begin
          commit      = 1'b1;
          commit_addr = s_axi.s_axi_awaddr;
          wr_state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.s_axi_bready) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    // Readies are held low during reset, so nothing may commit either.
    if (reset) begin
      awready = 1'b0;
      wready  = 1'b0;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      aw_addr_q  <= 32'h0;
      w_data_q   <= 32'h0;
      w_strb_q   <= 4'h0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      if (awready && s_axi.s_axi_awvalid) begin
        aw_addr_q <= s_axi.s_axi_awaddr;
      end
      if (wready && s_axi.s_axi_wvalid) begin
        w_data_q <= s_axi.s_axi_wdata;
        w_strb_q <= s_axi.s_axi_wstrb;
      end
      if (commit) begin
        bresp_q <= in_range(commit_addr) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // RAM array has no reset; only the commit strobe gates writes.
  always_ff @(posedge clk) begin
    if (commit && in_range(commit_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_strb[i]) begin
          mem[commit_addr[TAG_LSB-1:2]][8*i +: 8] <= commit_data[8*i +: 8];
        end
      end
    end
  end

  assign s_axi.s_axi_awready = awready;
  assign s_axi.s_axi_wready  = wready;
  assign s_axi.s_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s_axi.s_axi_bresp   = bresp_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_t   rd_state_q, rd_state_d;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        arready;
  logic        ar_hs;

  always_comb begin
    rd_state_d = rd_state_q;
    arready    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        arready = 1'b1;
        if (s_axi.s_axi_arvalid) begin
          rd_state_d = RD_VALID;
        end
      end
      RD_VALID: begin
        if (s_axi.s_axi_rready) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (reset) begin
      arready = 1'b0;
    end
  end

  assign ar_hs = arready && s_axi.s_axi_arvalid;

  // mem is sampled here before the write block's update lands, so a read and
  // a write to the same word on one edge return the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= 32'h0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        if (in_range(s_axi.s_axi_araddr)) begin
          rdata_q <= mem[s_axi.s_axi_araddr[TAG_LSB-1:2]];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= 32'h0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  assign s_axi.s_axi_arready = arready;
  assign s_axi.s_axi_rvalid  = (rd_state_q == RD_VALID);
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

  assign wr_state_dbg = wr_state_q;
  assign rd_state_dbg = rd_state_q;

endmodule
